// File: rtl/ns_msg_relay_pkg.sv
// Shared constants, FSM state types and the redundancy function for the ns message relay.
package ns_msg_relay_pkg;

    localparam int unsigned NS_ADDRESS_SIZE = 4;
    localparam int unsigned NS_DATA_SIZE    = 8;
    localparam int unsigned NS_REDUN_SIZE   = 4;
    localparam int unsigned NS_MSG_SIZE     = 2 * NS_ADDRESS_SIZE + NS_DATA_SIZE + NS_REDUN_SIZE;

    localparam logic NS_ON  = 1'b1;
    localparam logic NS_OFF = 1'b0;

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_CHK  = 2'd1,
        IN_ACK  = 2'd2
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_REL  = 2'd2
    } out_state_e;

    // XOR-fold of {src, dst, dat} into NS_REDUN_SIZE-bit chunks.
    function automatic logic [NS_REDUN_SIZE-1:0] calc_redun(
        input logic [NS_ADDRESS_SIZE-1:0] src,
        input logic [NS_ADDRESS_SIZE-1:0] dst,
        input logic [NS_DATA_SIZE-1:0]    dat
    );
        localparam int unsigned FW = 2 * NS_ADDRESS_SIZE + NS_DATA_SIZE;
        logic [FW-1:0]            flat;
        logic [NS_REDUN_SIZE-1:0] red;
        flat = {src, dst, dat};
        red  = '0;
        for (int unsigned c = 0; c < (FW + NS_REDUN_SIZE - 1) / NS_REDUN_SIZE; c++) begin
            red = red ^ NS_REDUN_SIZE'(flat >> (c * NS_REDUN_SIZE));
        end
        return red;
    endfunction

endpackage

// File: rtl/ns_msg_relay_fifo.sv
// ns_msg_fifo: DEPTH-entry message FIFO with wrapping pointers and an occupancy count.
module ns_msg_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ASZ   = 4,
    parameter int unsigned DSZ   = 8,
    parameter int unsigned RSZ   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [2*ASZ+DSZ+RSZ-1:0]     wdata_i,
    input  logic                         pop_i,
    output logic [2*ASZ+DSZ+RSZ-1:0]     rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned MW = 2 * ASZ + DSZ + RSZ;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [MW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Simultaneous push and pop both advance their pointers and cancel in the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/ns_msg_relay.sv
// ns_msg_relay: 4-phase in/out message relay with redundancy check and FIFO decoupling.
// Define NS_RELAY_DROP_BAD_EN to discard messages whose redundancy field mismatches.
module ns_msg_relay
    import ns_msg_relay_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ASZ   = NS_ADDRESS_SIZE,
    parameter int unsigned DSZ   = NS_DATA_SIZE,
    parameter int unsigned RSZ   = NS_REDUN_SIZE
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic [3:0]     dbg_leds,
    output logic [3:0]     dbg_disp0,
    output logic [3:0]     dbg_disp1
);

    localparam int unsigned MW = 2 * ASZ + DSZ + RSZ;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    in_state_e      in_state_q;
    out_state_e     out_state_q;
    logic [ASZ-1:0] stg_src_q;
    logic [ASZ-1:0] stg_dst_q;
    logic [DSZ-1:0] stg_dat_q;
    logic [RSZ-1:0] stg_red_q;
    logic           i0_ack_q;
    logic           err_flag_q;
    logic [3:0]     err_cnt_q;
    logic [ASZ-1:0] o0_src_q;
    logic [ASZ-1:0] o0_dst_q;
    logic [DSZ-1:0] o0_dat_q;
    logic [RSZ-1:0] o0_red_q;
    logic           o0_req_q;

    logic           red_ok;
    logic           push_c;
    logic           pop_c;
    logic [MW-1:0]  head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    assign red_ok = (stg_red_q == calc_redun(stg_src_q, stg_dst_q, stg_dat_q));

`ifdef NS_RELAY_DROP_BAD_EN
    assign push_c = (in_state_q == IN_CHK) && red_ok;
`else
    assign push_c = (in_state_q == IN_CHK);
`endif

    assign pop_c = (out_state_q == OUT_REQ) && o0_ack;

    ns_msg_fifo #(
        .DEPTH (DEPTH),
        .ASZ   (ASZ),
        .DSZ   (DSZ),
        .RSZ   (RSZ)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .wdata_i ({stg_src_q, stg_dst_q, stg_dat_q, stg_red_q}),
        .pop_i   (pop_c),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Input handshake: stage, check, acknowledge; full FIFO holds the request in IN_IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_state_q <= IN_IDLE;
            stg_src_q  <= '0;
            stg_dst_q  <= '0;
            stg_dat_q  <= '0;
            stg_red_q  <= '0;
            i0_ack_q   <= NS_OFF;
            err_flag_q <= NS_OFF;
            err_cnt_q  <= '0;
        end else begin
            case (in_state_q)
                IN_IDLE: begin
                    if (i0_req && !i0_ack_q && !fifo_full) begin
                        stg_src_q  <= i0_src;
                        stg_dst_q  <= i0_dst;
                        stg_dat_q  <= i0_dat;
                        stg_red_q  <= i0_red;
                        in_state_q <= IN_CHK;
                    end
                end
                IN_CHK: begin
                    if (!red_ok) begin
                        err_flag_q <= NS_ON;
                        if (err_cnt_q != 4'hF) begin
                            err_cnt_q <= err_cnt_q + 4'd1;
                        end
                    end
                    i0_ack_q   <= NS_ON;
                    in_state_q <= IN_ACK;
                end
                IN_ACK: begin
                    if (!i0_req) begin
                        i0_ack_q   <= NS_OFF;
                        in_state_q <= IN_IDLE;
                    end
                end
                default: in_state_q <= IN_IDLE;
            endcase
        end
    end

    // Output handshake: fields are loaded once per message and held until the pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_state_q <= OUT_IDLE;
            o0_src_q    <= '0;
            o0_dst_q    <= '0;
            o0_dat_q    <= '0;
            o0_red_q    <= '0;
            o0_req_q    <= NS_OFF;
        end else begin
            case (out_state_q)
                OUT_IDLE: begin
                    if (!fifo_empty && !o0_ack) begin
                        {o0_src_q, o0_dst_q, o0_dat_q, o0_red_q} <= head;
                        o0_req_q    <= NS_ON;
                        out_state_q <= OUT_REQ;
                    end
                end
                OUT_REQ: begin
                    if (o0_ack) begin
                        o0_req_q    <= NS_OFF;
                        out_state_q <= OUT_REL;
                    end
                end
                OUT_REL: begin
                    if (!o0_ack) begin
                        out_state_q <= OUT_IDLE;
                    end
                end
                default: out_state_q <= OUT_IDLE;
            endcase
        end
    end

    assign i0_ack    = i0_ack_q;
    assign o0_src    = o0_src_q;
    assign o0_dst    = o0_dst_q;
    assign o0_dat    = o0_dat_q;
    assign o0_red    = o0_red_q;
    assign o0_req    = o0_req_q;
    assign dbg_leds  = {o0_req_q, fifo_empty, fifo_full, err_flag_q};
    assign dbg_disp0 = err_cnt_q;
    assign dbg_disp1 = 4'(fifo_count);

endmodule

// File: tb/tb_ns_msg_relay.sv
// Directed bench for ns_msg_relay with an expected-message queue checked at the output sink.
module tb_ns_msg_relay;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i0_src, i0_dst, i0_red;
    logic [7:0] i0_dat;
    logic       i0_req;
    logic       i0_ack;
    logic [3:0] o0_src, o0_dst, o0_red;
    logic [7:0] o0_dat;
    logic       o0_req;
    logic       o0_ack;
    logic [3:0] dbg_leds, dbg_disp0, dbg_disp1;

`ifdef NS_RELAY_DROP_BAD_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [19:0] exp_q[$];
    bit          sink_en  = 1'b0;

    always #5 clk = ~clk;

    ns_msg_relay dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i0_src    (i0_src),
        .i0_dst    (i0_dst),
        .i0_dat    (i0_dat),
        .i0_red    (i0_red),
        .i0_req    (i0_req),
        .i0_ack    (i0_ack),
        .o0_src    (o0_src),
        .o0_dst    (o0_dst),
        .o0_dat    (o0_dat),
        .o0_red    (o0_red),
        .o0_req    (o0_req),
        .o0_ack    (o0_ack),
        .dbg_leds  (dbg_leds),
        .dbg_disp0 (dbg_disp0),
        .dbg_disp1 (dbg_disp1)
    );

    // Nibble XOR of src, dst and both halves of dat.
    function automatic logic [3:0] exp_red(input logic [3:0] s, input logic [3:0] d, input logic [7:0] t);
        return s ^ d ^ t[3:0] ^ t[7:4];
    endfunction

    function automatic logic [19:0] pack(input logic [3:0] s, input logic [3:0] d,
                                         input logic [7:0] t, input logic [3:0] r);
        return {s, d, t, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [3:0] d, input logic [7:0] t, input logic [3:0] r);
        i0_src = s;
        i0_dst = d;
        i0_dat = t;
        i0_red = r;
        i0_req = 1'b1;
    endtask

    task automatic wait_ack(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (i0_ack === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_oreq(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (o0_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [3:0] s, input logic [3:0] d, input logic [7:0] t,
                        input logic [3:0] r, input bit fwd, input string tag);
        bit ok;
        if (fwd) exp_q.push_back(pack(s, d, t, r));
        @(negedge clk);
        drive(s, d, t, r);
        wait_ack(1'b1, 20, ok);
        chk({tag, "_ack"}, 32'(ok), 32'd1);
        i0_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        chk({tag, "_rel"}, 32'(ok), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && o0_req === 1'b0 && o0_ack === 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_q.size() == 0 && o0_req === 1'b0 && o0_ack === 1'b0), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Output sink: 4-phase acknowledge, comparing each presented message with the queue head.
    initial begin
        o0_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (sink_en) begin
                if (o0_req === 1'b1 && o0_ack === 1'b0) begin
                    chk("sink_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        chk("sink_msg", 32'({o0_src, o0_dst, o0_dat, o0_red}), 32'(exp_q.pop_front()));
                    end
                    o0_ack = 1'b1;
                end else if (o0_ack === 1'b1 && o0_req === 1'b0) begin
                    o0_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        bit ok;
        logic [3:0] r;

        rst_n  = 1'b0;
        i0_req = 1'b0;
        i0_src = '0;
        i0_dst = '0;
        i0_dat = '0;
        i0_red = '0;
        repeat (3) @(negedge clk);
        chk("rst_i0_ack", 32'(i0_ack), 32'd0);
        chk("rst_o0_req", 32'(o0_req), 32'd0);
        chk("rst_fields", 32'({o0_src, o0_dst, o0_dat, o0_red}), 32'd0);
        chk("rst_leds", 32'(dbg_leds), 32'h4);
        chk("rst_disp0", 32'(dbg_disp0), 32'd0);
        chk("rst_disp1", 32'(dbg_disp1), 32'd0);
        rst_n = 1'b1;

        // Single good message: latency and cut-through.
        @(negedge clk);
        r = exp_red(4'd9, 4'd10, 8'd3);
        exp_q.push_back(pack(4'd9, 4'd10, 8'd3, r));
        drive(4'd9, 4'd10, 8'd3, r);
        @(negedge clk);
        chk("t1_ack_edge1", 32'(i0_ack), 32'd0);
        @(negedge clk);
        chk("t1_ack_edge2", 32'(i0_ack), 32'd1);
        chk("t1_disp1", 32'(dbg_disp1), 32'd1);
        chk("t1_oreq_early", 32'(o0_req), 32'd0);
        @(negedge clk);
        chk("t1_oreq", 32'(o0_req), 32'd1);
        chk("t1_fields", 32'({o0_src, o0_dst, o0_dat, o0_red}), 32'(pack(4'd9, 4'd10, 8'd3, r)));
        chk("t1_leds", 32'(dbg_leds), 32'h8);
        i0_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        chk("t1_rel", 32'(ok), 32'd1);
        sink_en = 1'b1;
        drain("t1");
        chk("t1_empty_led", 32'(dbg_leds[2]), 32'd1);
        chk("t1_disp1_end", 32'(dbg_disp1), 32'd0);

        // Backpressure: sink stalled, 5th message must wait.
        sink_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(4'd1, 4'd2, 8'(i), exp_red(4'd1, 4'd2, 8'(i)), 1'b1, "t2_fill");
        end
        r = exp_red(4'd1, 4'd2, 8'd4);
        exp_q.push_back(pack(4'd1, 4'd2, 8'd4, r));
        @(negedge clk);
        drive(4'd1, 4'd2, 8'd4, r);
        wait_ack(1'b1, 10, ok);
        chk("t2_blocked", 32'(ok), 32'd0);
        chk("t2_full_led", 32'(dbg_leds[1]), 32'd1);
        chk("t2_disp1", 32'(dbg_disp1), 32'd4);
        chk("t2_leds", 32'(dbg_leds), 32'ha);
        sink_en = 1'b1;
        wait_ack(1'b1, 60, ok);
        chk("t2_unblocked", 32'(ok), 32'd1);
        i0_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        chk("t2_rel5", 32'(ok), 32'd1);
        send(4'd1, 4'd2, 8'd5, exp_red(4'd1, 4'd2, 8'd5), 1'b1, "t2_last");
        drain("t2");

        // One corrupted message.
        send(4'd3, 4'd4, 8'd7, exp_red(4'd3, 4'd4, 8'd7) ^ 4'h1, !DROP, "t3");
        drain("t3");
        chk("t3_disp0", 32'(dbg_disp0), 32'd1);
        chk("t3_err_led", 32'(dbg_leds[0]), 32'd1);

        // Error counter saturation.
        for (int i = 0; i < 20; i++) begin
            send(4'd5, 4'd6, 8'(i), exp_red(4'd5, 4'd6, 8'(i)) ^ 4'h1, !DROP, "t4");
            if (i == 13) chk("t4_disp0_at15", 32'(dbg_disp0), 32'd15);
        end
        drain("t4");
        chk("t4_disp0_sat", 32'(dbg_disp0), 32'd15);

        // Overlapped push and pop with two entries held.
        sink_en = 1'b0;
        send(4'd7, 4'd8, 8'h20, exp_red(4'd7, 4'd8, 8'h20), 1'b1, "t5_a");
        send(4'd7, 4'd8, 8'h21, exp_red(4'd7, 4'd8, 8'h21), 1'b1, "t5_b");
        wait_oreq(20, ok);
        chk("t5_oreq", 32'(ok), 32'd1);
        chk("t5_fill", 32'(dbg_disp1), 32'd2);
        for (int k = 0; k < 3; k++) begin
            chk("t5_head", 32'({o0_src, o0_dst, o0_dat, o0_red}), 32'(exp_q.pop_front()));
            r = exp_red(4'd7, 4'd8, 8'(8'h30 + k));
            exp_q.push_back(pack(4'd7, 4'd8, 8'(8'h30 + k), r));
            drive(4'd7, 4'd8, 8'(8'h30 + k), r);
            @(negedge clk);
            o0_ack = 1'b1;
            @(negedge clk);
            chk("t5_same_edge_disp1", 32'(dbg_disp1), 32'd2);
            chk("t5_same_edge_ack", 32'(i0_ack), 32'd1);
            chk("t5_same_edge_oreq", 32'(o0_req), 32'd0);
            i0_req = 1'b0;
            o0_ack = 1'b0;
            @(negedge clk);
            chk("t5_disp1_hold", 32'(dbg_disp1), 32'd2);
            chk("t5_ack_low", 32'(i0_ack), 32'd0);
            @(negedge clk);
            chk("t5_reload", 32'(o0_req), 32'd1);
        end
        sink_en = 1'b1;
        drain("t5");
        chk("t5_all_delivered", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of both handshakes.
        sink_en = 1'b0;
        send(4'd2, 4'd3, 8'h40, exp_red(4'd2, 4'd3, 8'h40), 1'b1, "t6_a");
        wait_oreq(20, ok);
        chk("t6_oreq_up", 32'(ok), 32'd1);
        @(negedge clk);
        drive(4'd2, 4'd3, 8'h41, exp_red(4'd2, 4'd3, 8'h41));
        wait_ack(1'b1, 20, ok);
        chk("t6_ack_up", 32'(ok), 32'd1);
        chk("t6_oreq_still", 32'(o0_req), 32'd1);
        rst_n  = 1'b0;
        i0_req = 1'b0;
        @(negedge clk);
        chk("t6_i0_ack", 32'(i0_ack), 32'd0);
        chk("t6_o0_req", 32'(o0_req), 32'd0);
        chk("t6_disp1", 32'(dbg_disp1), 32'd0);
        chk("t6_leds", 32'(dbg_leds), 32'h4);
        chk("t6_disp0", 32'(dbg_disp0), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        sink_en = 1'b1;
        send(4'd6, 4'd5, 8'h55, exp_red(4'd6, 4'd5, 8'h55), 1'b1, "t6_post");
        drain("t6");
        chk("t6_post_leds", 32'(dbg_leds), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
